// File: rtl/reg_wb_queue_if.sv
// ---------------------------------------------------------------------------
// reg_wb_queue_if
//   Bundles the writeback queue's execute-side handshake, register file write
//   port, bypass lookup port and status outputs.
//   Modports:
//     slave  - the queue itself (accepts results, drives writes and bypass)
//     master - the surrounding pipeline (execute, register file, decode)
//   Signals:
//     in_valid/in_ready/in_addr/in_data   execute result handshake
//     rf_stall                            write port busy this cycle
//     rf_wr_en/rf_wr_addr/rf_wr_data      register file write port
//     lk_addr1/lk_addr2                   bypass lookup addresses
//     byp_hit1/byp_data1/byp_hit2/byp_data2  bypass results
//     count/empty                         occupancy status
// ---------------------------------------------------------------------------
interface reg_wb_queue_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int DEPTH      = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  rf_stall;
  logic                  rf_wr_en;
  logic [ADDR_WIDTH-1:0] rf_wr_addr;
  logic [DATA_WIDTH-1:0] rf_wr_data;
  logic [ADDR_WIDTH-1:0] lk_addr1;
  logic [ADDR_WIDTH-1:0] lk_addr2;
  logic                  byp_hit1;
  logic [DATA_WIDTH-1:0] byp_data1;
  logic                  byp_hit2;
  logic [DATA_WIDTH-1:0] byp_data2;
  logic [CNT_W-1:0]      count;
  logic                  empty;

  modport slave (
    input  in_valid, in_addr, in_data, rf_stall, lk_addr1, lk_addr2,
    output in_ready, rf_wr_en, rf_wr_addr, rf_wr_data,
           byp_hit1, byp_data1, byp_hit2, byp_data2, count, empty
  );

  modport master (
    output in_valid, in_addr, in_data, rf_stall, lk_addr1, lk_addr2,
    input  in_ready, rf_wr_en, rf_wr_addr, rf_wr_data,
           byp_hit1, byp_data1, byp_hit2, byp_data2, count, empty
  );
endinterface

// File: rtl/reg_wb_queue.sv
// ---------------------------------------------------------------------------
// reg_wb_queue
//   In-order writeback buffer in front of the register file write port.
//   Execute results are accepted over a valid/ready handshake, held in a
//   DEPTH-entry circular queue and drained one per cycle whenever the write
//   port is free. Decode can look up two addresses and see the youngest
//   pending value for each. Register 0 is hardwired zero: results for it are
//   acknowledged but discarded, and it never produces a bypass hit.
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous active-high reset; discards all pending entries
//     bus  - reg_wb_queue_if.slave (handshake, write port, bypass, status)
// ---------------------------------------------------------------------------
module reg_wb_queue #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int DEPTH      = 4
) (
  input  logic           clk,
  input  logic           rst,
  reg_wb_queue_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_d [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_d [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic                  full_s;
  logic                  empty_s;
  logic                  accept_s;
  logic                  store_s;
  logic                  pop_s;
  logic [PTR_W-1:0]      idx_s;
  logic                  hit1_s, hit2_s;
  logic [DATA_WIDTH-1:0] bdata1_s, bdata2_s;

  // Handshake, drain and occupancy decode.
  always_comb begin
    full_s   = (count_q == CNT_W'(DEPTH));
    empty_s  = (count_q == CNT_W'(0));
    accept_s = bus.in_valid & ~full_s;
    // r0 results complete the handshake but are never stored.
    store_s  = accept_s & (bus.in_addr != {ADDR_WIDTH{1'b0}});
    pop_s    = ~empty_s & ~bus.rf_stall;
  end

  // Next-state for pointers, count and entry storage.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    addr_d   = addr_q;
    data_d   = data_q;
    if (store_s) begin
      addr_d[wr_ptr_q] = bus.in_addr;
      data_d[wr_ptr_q] = bus.in_data;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({store_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Bypass scan from oldest to youngest so the youngest match wins.
  always_comb begin
    hit1_s   = 1'b0;
    hit2_s   = 1'b0;
    bdata1_s = {DATA_WIDTH{1'b0}};
    bdata2_s = {DATA_WIDTH{1'b0}};
    idx_s    = rd_ptr_q;
    for (int i = 0; i < DEPTH; i++) begin
      idx_s = rd_ptr_q + PTR_W'(i);
      if (CNT_W'(i) < count_q) begin
        if ((bus.lk_addr1 != {ADDR_WIDTH{1'b0}}) && (addr_q[idx_s] == bus.lk_addr1)) begin
          hit1_s   = 1'b1;
          bdata1_s = data_q[idx_s];
        end else begin
          hit1_s   = hit1_s;
          bdata1_s = bdata1_s;
        end
        if ((bus.lk_addr2 != {ADDR_WIDTH{1'b0}}) && (addr_q[idx_s] == bus.lk_addr2)) begin
          hit2_s   = 1'b1;
          bdata2_s = data_q[idx_s];
        end else begin
          hit2_s   = hit2_s;
          bdata2_s = bdata2_s;
        end
      end else begin
        hit1_s = hit1_s;
        hit2_s = hit2_s;
      end
    end
  end

  // Output drive: head entry is shown only while the queue holds something.
  always_comb begin
    bus.in_ready  = ~full_s;
    bus.rf_wr_en  = pop_s;
    bus.count     = count_q;
    bus.empty     = empty_s;
    bus.byp_hit1  = hit1_s;
    bus.byp_data1 = bdata1_s;
    bus.byp_hit2  = hit2_s;
    bus.byp_data2 = bdata2_s;
    if (empty_s) begin
      bus.rf_wr_addr = {ADDR_WIDTH{1'b0}};
      bus.rf_wr_data = {DATA_WIDTH{1'b0}};
    end else begin
      bus.rf_wr_addr = addr_q[rd_ptr_q];
      bus.rf_wr_data = data_q[rd_ptr_q];
    end
  end

  // State registers; reset drops every pending entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= PTR_W'(0);
      rd_ptr_q <= PTR_W'(0);
      count_q  <= CNT_W'(0);
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= {ADDR_WIDTH{1'b0}};
        data_q[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end
endmodule
